// File: rtl/pio_cmd_engine.sv
// Command engine for the HPS PIO: decodes a captured command word and performs
// NOP / WRITE / READ / CLEAR against two 256x8 banks with synchronous-read storage.
module pio_cmd_engine #(
  parameter logic [7:0] CLEAR_VAL  = 8'h00,
  parameter bit         RSVD_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [28:0] instruct,
  input  logic        enable,
  input  logic        mem_sel,
  output logic [3:0]  flags,
  output logic [7:0]  data_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    RD_WAIT = 2'd2,
    CLR     = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_READ  = 3'b010;
  localparam logic [2:0] OP_CLEAR = 3'b011;

  state_t      state;
  logic        en_q;
  logic [28:0] cmd_p0;
  logic        bank_p0;
  logic [7:0]  clr_cnt;
  logic [7:0]  rd_data_p1;
  logic        start;

  logic [7:0]  mem [0:511];
  logic        mem_we;
  logic [8:0]  mem_waddr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic [8:0]  mem_raddr;

  wire  [2:0]  cmd_op   = cmd_p0[2:0];
  wire  [7:0]  cmd_addr = cmd_p0[10:3];
  wire  [7:0]  cmd_wdat = cmd_p0[18:11];

  function automatic logic cmd_invalid(input logic [28:0] c);
    logic bad_op;
    logic bad_rsvd;
    bad_op   = (c[2:0] > OP_CLEAR);
    bad_rsvd = RSVD_CHECK && (|c[28:19]);
    return bad_op || bad_rsvd;
  endfunction

  assign start = (state == IDLE) && enable && !en_q;

  // Stage p0: command capture; the running command only ever sees these copies
  always_ff @(posedge clk) begin
    if (start && !reset) begin
      cmd_p0  <= instruct;
      bank_p0 <= mem_sel;
    end
  end

  // Storage port control; a reset edge suppresses any pending write
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = {bank_p0, cmd_addr};
    mem_wdata = cmd_wdat;
    mem_re    = 1'b0;
    mem_raddr = {bank_p0, cmd_addr};
    if (!reset) begin
      case (state)
        EXEC: begin
          if (!cmd_invalid(cmd_p0)) begin
            case (cmd_op)
              OP_WRITE: mem_we = 1'b1;
              OP_READ:  mem_re = 1'b1;
              OP_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = {bank_p0, 8'h00};
                mem_wdata = CLEAR_VAL;
              end
              default: ;
            endcase
          end
        end
        CLR: begin
          mem_we    = 1'b1;
          mem_waddr = {bank_p0, clr_cnt};
          mem_wdata = CLEAR_VAL;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: storage write and registered read
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    if (mem_re) begin
      rd_data_p1 <= mem[mem_raddr];
    end
  end

  // Control FSM; flags = {bank, error, busy, done}
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      en_q     <= 1'b1;
      flags    <= 4'b0000;
      data_out <= 8'h00;
      clr_cnt  <= 8'h00;
    end else begin
      en_q <= enable;
      case (state)
        IDLE: begin
          if (start) begin
            flags <= {mem_sel, 1'b0, 1'b1, 1'b0};
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cmd_invalid(cmd_p0)) begin
            flags[2:0] <= 3'b101;
            state      <= IDLE;
          end else begin
            case (cmd_op)
              OP_READ:  state <= RD_WAIT;
              OP_CLEAR: begin
                clr_cnt <= 8'h01;
                state   <= CLR;
              end
              default: begin
                flags[1:0] <= 2'b01;
                state      <= IDLE;
              end
            endcase
          end
        end
        RD_WAIT: begin
          data_out   <= rd_data_p1;
          flags[1:0] <= 2'b01;
          state      <= IDLE;
        end
        CLR: begin
          clr_cnt <= clr_cnt + 8'h01;
          if (clr_cnt == 8'hFF) begin
            flags[1:0] <= 2'b01;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pio_cmd_engine.md
PIO_CMD_ENGINE -- requirements
Module: pio_cmd_engine

Interface
REQ-001 SHALL have parameter CLEAR_VAL, default 8'h00: byte written to every location by CLEAR.
REQ-002 SHALL have parameter RSVD_CHECK, default 1: when 1, nonzero instruct[28:19] is an error.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port instruct, input, 29: command word from the HPS PIO.
REQ-006 SHALL have port enable, input, 1: command strobe from the HPS PIO; a rising edge starts a command.
REQ-007 SHALL have port mem_sel, input, 1: bank select, captured together with instruct.
REQ-008 SHALL have port flags, output, 4: status to the HPS PIO; [0] done, [1] busy, [2] error, [3] bank of the last captured command.
REQ-009 SHALL have port data_out, output, 8: read result to the HPS PIO.

Function
REQ-010 SHALL decode instruct fields as follows: [2:0] opcode, [10:3] addr, [18:11] wdata, [28:19] reserved.
REQ-011 SHALL hold two banks of 256x8 storage, with mem_sel selecting the bank; storage SHALL use synchronous read with 1-cycle read latency.
REQ-012 SHALL support these opcodes: 000 NOP, 001 WRITE, 010 READ, 011 CLEAR; every other opcode is invalid.
REQ-013 SHALL detect the rising edge of enable as enable=1 and en_q=0, where en_q is enable registered each cycle.
REQ-014 SHALL, on the edge where the rising edge is detected (edge k) while in IDLE, capture instruct and mem_sel, set busy=1, clear done and error, set flags[3]=mem_sel, and enter EXEC.
REQ-015 SHALL ignore enable edges unless in IDLE; instruct and mem_sel changes after capture SHALL have no effect on the running command.
REQ-016 SHALL use states IDLE, EXEC, RD_WAIT and CLR.
- EXEC exits to IDLE, RD_WAIT or CLR.
- RD_WAIT and CLR exit to IDLE.
REQ-017 SHALL complete NOP at edge k+1: busy=0, done=1.
REQ-018 SHALL complete WRITE at edge k+1: storage[bank][addr] is written with wdata; busy=0, done=1.
REQ-019 SHALL complete READ as follows: address issued at edge k+1, data_out updated at edge k+2, busy=0 and done=1 at edge k+2.
REQ-020 SHALL complete CLEAR as follows: CLEAR_VAL written to addresses 0..255 of the selected bank on edges k+1..k+256 via an 8-bit counter; the counter wraps 255->0 exactly once; busy=0 and done=1 at edge k+256.
REQ-021 SHALL complete an invalid opcode, or a reserved-field violation when RSVD_CHECK=1, at edge k+1 with error=1, done=1, busy=0, and no storage access.
REQ-022 SHALL hold data_out except on READ completion; WRITE and CLEAR SHALL NOT modify data_out.
REQ-023 SHALL hold done and error until the next command capture; enable falling SHALL NOT clear them.
REQ-024 SHALL accept a new command when a rising edge occurs on the same edge the prior command returns to IDLE only from the following cycle; that edge SHALL be consumed (lost), and software retries after observing done.
REQ-025 SHALL return data written to the same bank and address by an earlier WRITE when READ is performed back-to-back after it (no stale data).

Reset
REQ-026 SHALL, on reset sampled high, force state=IDLE, flags=4'b0000, data_out=8'h00 and the CLEAR counter=0 on that edge, including mid-command.
REQ-027 SHALL reset en_q to 1 so that enable held high through reset release does not start a command.
REQ-028 SHALL NOT initialise storage contents on reset; contents SHALL be retained across reset.

Verification
REQ-029 SHALL be verified by this scenario: WRITE bank0 addr 0x12 wdata 0xA5, then READ bank0 addr 0x12 -> data_out=0xA5 at k+2 and flags=4'b0001.
REQ-030 SHALL be verified by this scenario: WRITE bank1 addr 0x12 0x3C, then READ bank0 addr 0x12 -> data_out=0xA5 (banks independent) and flags[3]=0.
REQ-031 SHALL be verified by this scenario: CLEAR bank0 -> busy high for exactly 256 cycles; READ addr 0x00 and 0xFF -> 0x00.
REQ-032 SHALL be verified by this scenario: opcode 3'b101, then instruct[28:19]=10'h001 with NOP -> each gives flags=4'b0101, with storage and data_out unchanged.
REQ-033 SHALL be verified by this scenario: reset asserted at cycle 100 of a CLEAR -> flags=0 and data_out=0 next edge; addresses below 99 hold CLEAR_VAL and higher addresses hold old data.
REQ-034 SHALL be verified by this scenario: enable held high across reset release -> no command; enable toggled 0->1 during busy -> ignored.
